id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode and ID/EX pipeline-register stage directly upstream of the execute ALU.
- Takes a fetched instruction plus register-file read data.
- Decodes the instruction into the ALU control and operand fields (opcode, shamt, funct, sign-extended immd, ALUOp, ALUSrc) and the downstream memory/writeback controls.
- Registers those results for one cycle under a valid/ready handshake.
- Inserts a bubble on load-use hazards and supports a branch flush.

Parameters:
- DW, 32, data and instruction width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_valid  in  1  if_instr, if_pc and the register-file read data are valid.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of the instruction.
- rs_data  in  32  register-file read of instr[25:21].
- rt_data  in  32  register-file read of instr[20:16].
- id_ready  out  1  the stage accepts the instruction this cycle.
- flush  in  1  branch mispredict; kill the instruction being accepted this cycle.
- ex_ready  in  1  the execute stage consumes the EX register this cycle.
- ex_valid  out  1  the EX register holds a live instruction.
- read_data1, read_data2  out  32  registered rs_data / rt_data.
- opcode  out  6  registered instruction field.
- shamt  out  5  registered instruction field.
- funct  out  6  registered instruction field.
- immd  out  32  registered sign-extended instr[15:0].
- ALUOp  out  2  registered ALU control.
- ALUSrc  out  1  registered ALU control.
- ex_pc  out  32  registered PC.
- ex_dest  out  5  registered destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered controls.
- illegal  out  1  registered flag: unsupported opcode was accepted.
- bubble_cnt  out  CNT_W  saturating count of inserted hazard bubbles.

Behaviour:
- Reset (asynchronous, rst=1): every registered output is 0. FSM enters RUN. bubble_cnt=0.
- Decode table (combinational on if_instr):
  - R-type (000000): ALUOp=10, ALUSrc=0, dest=rd.
    - reg_write=1 unless funct=`NOP`.
    - funct=`LW`: mem_read=1. funct=`SW`: mem_write=1, reg_write=0.
  - ADDI (001000): ALUOp=00, ALUSrc=1, dest=rt, reg_write=1.
  - LW (100011): ALUOp=00, ALUSrc=1, dest=rt, reg_write=1, mem_read=1.
  - SW (101011): ALUOp=00, ALUSrc=1, mem_write=1.
  - BEQ (000100): ALUOp=01, ALUSrc=0, no writes.
  - Any other opcode: ALUOp=11, all writes 0, illegal=1.
- Sign extension: immd = {16{instr[15]}, instr[15:0]}.
- Register enable: load_en = !ex_valid || ex_ready. When load_en=0, all EX outputs hold.
- Hazard condition: hz = ex_valid && ex_mem_read && ex_dest!=0 && if_valid && (rs==ex_dest || (uses_rt && rt==ex_dest)).
  - uses_rt=1 for R-type, BEQ, SW.
- FSM states:
  - RUN, hz=0: id_ready=load_en. On accept, the EX register loads the decoded instruction and ex_valid=1. If load_en=1 and !if_valid, ex_valid becomes 0.
  - RUN, hz=1 and load_en=1: id_ready=0. EX loads a bubble (ex_valid=0, controls 0). bubble_cnt++ (saturates at all-ones). Next state HAZ.
  - HAZ: id_ready=load_en, hz ignored for one cycle. On accept, go to RUN.
  - Exactly one bubble per load-use pair.
- Flush: has priority over hz and accept.
  - id_ready=1; the incoming instruction is dropped.
  - If load_en, ex_valid becomes 0.
  - FSM returns to RUN. No bubble is counted.
  - The issuer guarantees the branch itself has already left EX.
- Throughput: one instruction per cycle, latency 1 cycle from accept to ex_valid.
- if_valid=0: id_ready follows load_en; nothing is decoded into EX.

Decomposition:
- Shared define header: opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ; ALUOp encodings. Reuse the existing funct defines (`NOP`, `ADD`, `SUB`, `AND`, `OR`, `XOR`, `SLT`, `SLL`, `SRL`, `LW`, `SW`, `ABS`).
- One sub-module, id_decode: purely combinational table producing control bits, dest and immd. The stage instantiates it and owns the register, FSM and counter.

Test Plan:
- Reset: rst high mid-stream with ex_valid=1 -> all outputs 0 immediately, without waiting for clk; first instruction after release is accepted normally.
- ADDI $2,$1,-4 (0x2022FFFC), ex_ready=1 -> next cycle: ALUOp=00, ALUSrc=1, immd=0xFFFFFFFC, ex_dest=2, ex_reg_write=1.
- LW $3,0($1) then ADD $4,$3,$5 back-to-back -> one cycle id_ready=0 and ex_valid=0; ADD enters EX the following cycle; bubble_cnt=1.
- LW $3 then ADD $4,$0,$0 -> no bubble, bubble_cnt stays 0.
- ex_ready=0 for 3 cycles with if_valid=1 -> id_ready=0 and EX outputs stable for all 3 cycles; accept resumes on the 4th.
- flush=1 while hz=1 -> instruction dropped, no bubble counted, FSM RUN.
- Opcode 111111 -> illegal=1, ALUOp=11, no write or memory enables.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants, control bundle and stage state for the ID/EX stage.
package id_ex_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH  = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h04;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_LW  = 6'h30;
  localparam logic [5:0] FN_SW  = 6'h31;
  localparam logic [5:0] FN_ABS = 6'h32;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic [4:0] dest;
  } dec_ctrl_t;

  typedef enum logic {ST_RUN, ST_HAZ} stage_state_t;

endpackage

// File: rtl/id_ex_stage_decode.sv
// Combinational instruction decode: field split, sign extension and control table.
import id_ex_stage_pkg::*;

module id_decode #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] instr,
  output logic [5:0]    opcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    shamt,
  output logic [5:0]    funct,
  output logic [DW-1:0] immd,
  output logic          uses_rt,
  output dec_ctrl_t     ctrl
);

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign immd   = {{(DW-16){instr[15]}}, instr[15:0]};

  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.alu_op    = ALUOP_RTYPE;
        ctrl.dest      = instr[15:11];
        ctrl.reg_write = (funct != FN_NOP) && (funct != FN_SW);
        ctrl.mem_read  = (funct == FN_LW);
        ctrl.mem_write = (funct == FN_SW);
        uses_rt        = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.dest      = rt;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.dest      = rt;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALUOP_BRANCH;
        uses_rt     = 1'b1;
      end
      default: begin
        ctrl.alu_op  = ALUOP_ILLEGAL;
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and bubble counter.
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [DW-1:0]    if_instr,
  input  logic [DW-1:0]    if_pc,
  input  logic [DW-1:0]    rs_data,
  input  logic [DW-1:0]    rt_data,
  output logic             id_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [DW-1:0]    read_data1,
  output logic [DW-1:0]    read_data2,
  output logic [5:0]       opcode,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [DW-1:0]    immd,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic [DW-1:0]    ex_pc,
  output logic [4:0]       ex_dest,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [5:0]    dec_opcode;
  logic [4:0]    dec_rs;
  logic [4:0]    dec_rt;
  logic [4:0]    dec_shamt;
  logic [5:0]    dec_funct;
  logic [DW-1:0] dec_immd;
  logic          dec_uses_rt;
  dec_ctrl_t     dec_ctrl;

  id_decode #(.DW(DW)) u_decode (
    .instr   (if_instr),
    .opcode  (dec_opcode),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .shamt   (dec_shamt),
    .funct   (dec_funct),
    .immd    (dec_immd),
    .uses_rt (dec_uses_rt),
    .ctrl    (dec_ctrl)
  );

  stage_state_t state;
  dec_ctrl_t    ctrl_p0;
  logic         vld_p0;
  logic         load_en;
  logic         hz;
  logic         hz_eff;

  assign load_en = !vld_p0 || ex_ready;

  assign hz = vld_p0 && ctrl_p0.mem_read && (ctrl_p0.dest != 5'd0) && if_valid &&
              ((dec_rs == ctrl_p0.dest) || (dec_uses_rt && (dec_rt == ctrl_p0.dest)));

  // The cycle after a bubble the load has moved on, so the hazard is not re-raised.
  assign hz_eff = hz && (state == ST_RUN);

  always_comb begin
    id_ready = load_en;
    if (flush)       id_ready = 1'b1;
    else if (hz_eff) id_ready = 1'b0;
  end

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      vld_p0     <= 1'b0;
      ctrl_p0    <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      opcode     <= '0;
      shamt      <= '0;
      funct      <= '0;
      immd       <= '0;
      ex_pc      <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      state <= ST_RUN;
      if (load_en) begin
        vld_p0  <= 1'b0;
        ctrl_p0 <= '0;
      end
    end else if (hz_eff) begin
      if (load_en) begin
        vld_p0  <= 1'b0;
        ctrl_p0 <= '0;
        state   <= ST_HAZ;
        if (bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else if (load_en) begin
      if (if_valid) begin
        vld_p0     <= 1'b1;
        ctrl_p0    <= dec_ctrl;
        read_data1 <= rs_data;
        read_data2 <= rt_data;
        opcode     <= dec_opcode;
        shamt      <= dec_shamt;
        funct      <= dec_funct;
        immd       <= dec_immd;
        ex_pc      <= if_pc;
        state      <= ST_RUN;
      end else begin
        vld_p0  <= 1'b0;
        ctrl_p0 <= '0;
      end
    end
  end

  assign ex_valid     = vld_p0;
  assign ALUOp        = ctrl_p0.alu_op;
  assign ALUSrc       = ctrl_p0.alu_src;
  assign ex_dest      = ctrl_p0.dest;
  assign ex_reg_write = ctrl_p0.reg_write;
  assign ex_mem_read  = ctrl_p0.mem_read;
  assign ex_mem_write = ctrl_p0.mem_write;
  assign illegal      = ctrl_p0.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode fields, load-use bubble, stall, flush, async reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        id_ready;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [5:0]  opcode;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] immd;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic [31:0] ex_pc;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        illegal;
  logic [15:0] bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] I_ADDI    = 32'h2022FFFC; // addi $2,$1,-4
  localparam logic [31:0] I_LW3     = 32'h8C230000; // lw   $3,0($1)
  localparam logic [31:0] I_ADD_DEP = 32'h00652020; // add  $4,$3,$5
  localparam logic [31:0] I_ADD_Z   = 32'h00002020; // add  $4,$0,$0
  localparam logic [31:0] I_ILL     = 32'hFC000000; // opcode 111111
  localparam logic [31:0] I_BEQ     = 32'h10220008; // beq  $1,$2,8

  id_ex_stage #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rs_data(rs_data), .rt_data(rt_data), .id_ready(id_ready), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .read_data1(read_data1),
    .read_data2(read_data2), .opcode(opcode), .shamt(shamt), .funct(funct),
    .immd(immd), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ex_pc(ex_pc), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .illegal(illegal), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic rdy);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    rs_data  = pc ^ 32'hA5A5_0000;
    rt_data  = pc ^ 32'h0000_5A5A;
    flush    = fl;
    ex_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    step();
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_bubble_cnt", 32'(bubble_cnt), 32'd0);
    rst = 1'b0;

    // ADDI decode
    drive(1'b1, I_ADDI, 32'h100, 1'b0, 1'b1);
    check("addi_id_ready", 32'(id_ready), 32'd1);
    step();
    check("addi_ex_valid", 32'(ex_valid), 32'd1);
    check("addi_aluop", 32'(ALUOp), 32'd0);
    check("addi_alusrc", 32'(ALUSrc), 32'd1);
    check("addi_immd", immd, 32'hFFFFFFFC);
    check("addi_dest", 32'(ex_dest), 32'd2);
    check("addi_reg_write", 32'(ex_reg_write), 32'd1);
    check("addi_pc", ex_pc, 32'h100);
    check("addi_rd1", read_data1, 32'hA5A5_0100);

    // Load-use: LW $3 then ADD using $3
    drive(1'b1, I_LW3, 32'h104, 1'b0, 1'b1);
    step();
    check("lw_mem_read", 32'(ex_mem_read), 32'd1);
    check("lw_dest", 32'(ex_dest), 32'd3);
    drive(1'b1, I_ADD_DEP, 32'h108, 1'b0, 1'b1);
    check("hz_id_ready", 32'(id_ready), 32'd0);
    step();
    check("hz_bubble_valid", 32'(ex_valid), 32'd0);
    check("hz_bubble_cnt", 32'(bubble_cnt), 32'd1);
    check("hz_after_id_ready", 32'(id_ready), 32'd1);
    step();
    check("add_ex_valid", 32'(ex_valid), 32'd1);
    check("add_dest", 32'(ex_dest), 32'd4);
    check("add_aluop", 32'(ALUOp), 32'd2);
    check("add_funct", 32'(funct), 32'h20);
    check("add_rd2", read_data2, 32'h0000_5B52);

    // LW $3 then ADD $4,$0,$0: no dependency, no bubble
    drive(1'b1, I_LW3, 32'h10C, 1'b0, 1'b1);
    step();
    drive(1'b1, I_ADD_Z, 32'h110, 1'b0, 1'b1);
    check("nohz_id_ready", 32'(id_ready), 32'd1);
    step();
    check("nohz_ex_valid", 32'(ex_valid), 32'd1);
    check("nohz_pc", ex_pc, 32'h110);
    check("nohz_bubble_cnt", 32'(bubble_cnt), 32'd1);

    // Downstream stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, I_ADDI, 32'h114, 1'b0, 1'b0);
      check("stall_id_ready", 32'(id_ready), 32'd0);
      step();
      check("stall_pc_hold", ex_pc, 32'h110);
      check("stall_dest_hold", 32'(ex_dest), 32'd4);
    end
    drive(1'b1, I_ADDI, 32'h114, 1'b0, 1'b1);
    check("resume_id_ready", 32'(id_ready), 32'd1);
    step();
    check("resume_pc", ex_pc, 32'h114);
    check("resume_dest", 32'(ex_dest), 32'd2);

    // Flush while a load-use hazard is pending
    drive(1'b1, I_LW3, 32'h118, 1'b0, 1'b1);
    step();
    drive(1'b1, I_ADD_DEP, 32'h11C, 1'b1, 1'b1);
    check("flush_id_ready", 32'(id_ready), 32'd1);
    step();
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    check("flush_bubble_cnt", 32'(bubble_cnt), 32'd1);
    drive(1'b1, I_LW3, 32'h120, 1'b0, 1'b1);
    step();
    drive(1'b1, I_ADD_DEP, 32'h124, 1'b0, 1'b1);
    check("post_flush_hz", 32'(id_ready), 32'd0);
    step();
    check("post_flush_cnt", 32'(bubble_cnt), 32'd2);
    step();
    check("post_flush_add", ex_pc, 32'h124);

    // Illegal opcode
    drive(1'b1, I_ILL, 32'h128, 1'b0, 1'b1);
    step();
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_aluop", 32'(ALUOp), 32'd3);
    check("ill_writes", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);

    // BEQ decode
    drive(1'b1, I_BEQ, 32'h12C, 1'b0, 1'b1);
    step();
    check("beq_aluop", 32'(ALUOp), 32'd1);
    check("beq_ctrl", {28'd0, ALUSrc, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    check("beq_immd", immd, 32'h8);

    // Idle input empties EX
    drive(1'b0, I_ADDI, 32'h130, 1'b0, 1'b1);
    check("idle_id_ready", 32'(id_ready), 32'd1);
    step();
    check("idle_ex_valid", 32'(ex_valid), 32'd0);

    // Asynchronous reset mid-stream
    drive(1'b1, I_ADDI, 32'h134, 1'b0, 1'b1);
    step();
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(ex_valid), 32'd0);
    check("async_rst_immd", immd, 32'd0);
    check("async_rst_cnt", 32'(bubble_cnt), 32'd0);
    check("async_rst_pc", ex_pc, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, I_ADDI, 32'h138, 1'b0, 1'b1);
    check("rel_id_ready", 32'(id_ready), 32'd1);
    step();
    check("rel_ex_valid", 32'(ex_valid), 32'd1);
    check("rel_pc", ex_pc, 32'h138);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
